// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register slave.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Command frame as received, MSB first.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop input synchronizer with a history flop for rise/fall detection.
module sync_edge_det #(
  parameter int unsigned STAGES = 2,
  parameter logic        INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic synced,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] pipe;
  logic              hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= {STAGES{INIT}};
      hist <= INIT;
    end else begin
      pipe <= {pipe[STAGES-2:0], din};
      hist <= pipe[STAGES-1];
    end
  end

  assign synced = pipe[STAGES-1];
  assign rise_c = synced & ~hist;
  assign fall_c = ~synced & hist;

endmodule

// File: rtl/spi_reg_slave.sv
// Write-only SPI mode-0 slave feeding five 8-bit PWM/output-enable control registers.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        copi,
  input  logic        ncs,
  output logic [7:0]  en_out_7_0,
  output logic [7:0]  en_out_15_8,
  output logic [7:0]  en_pwm_7_0,
  output logic [7:0]  en_pwm_15_8,
  output logic [7:0]  pwm_duty,
  output logic        wr_strobe,
  output logic        frame_err
);

  logic sclk_sync, sclk_rise, sclk_fall_unused;
  logic copi_sync, copi_rise_unused, copi_fall_unused;
  logic ncs_sync, ncs_rise, ncs_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (sclk),
    .synced (sclk_sync),
    .rise_c (sclk_rise),
    .fall_c (sclk_fall_unused)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_copi_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (copi),
    .synced (copi_sync),
    .rise_c (copi_rise_unused),
    .fall_c (copi_fall_unused)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ncs_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (ncs),
    .synced (ncs_sync),
    .rise_c (ncs_rise),
    .fall_c (ncs_fall)
  );

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_BITS-1:0] shift_q;
  frame_t               frame_c;
  logic                 addr_ok_c;

  assign frame_c   = frame_t'(shift_q);
  assign addr_ok_c = 32'(frame_c.addr) <= MAX_ADDR;

  // The write is taken on the edge that enters COMMIT, so the strobe is high for the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      en_out_7_0  <= '0;
      en_out_15_8 <= '0;
      en_pwm_7_0  <= '0;
      en_pwm_15_8 <= '0;
      pwm_duty    <= '0;
      wr_strobe   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            shift_q <= '0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
            if (bit_cnt != CNT_FULL) begin
              frame_err <= 1'b1;
            end else if (frame_c.wr && addr_ok_c) begin
              wr_strobe <= 1'b1;
              case (frame_c.addr)
                ADDR_EN_OUT_7_0:  en_out_7_0  <= frame_c.data;
                ADDR_EN_OUT_15_8: en_out_15_8 <= frame_c.data;
                ADDR_EN_PWM_7_0:  en_pwm_7_0  <= frame_c.data;
                ADDR_EN_PWM_15_8: en_pwm_15_8 <= frame_c.data;
                ADDR_PWM_DUTY:    pwm_duty    <= frame_c.data;
                default: ;
              endcase
            end
          end else if (sclk_rise && !ncs_sync) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_sync};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic sclk_level_unused;
  assign sclk_level_unused = sclk_sync;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench: fixed vector table, hand sequences for latency/reset, random frames vs. a register-file model.
module tb_spi_reg_slave;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned MAX_ADDR    = 4;

  logic       clk = 1'b0;
  logic       rst, sclk, copi, ncs;
  logic [7:0] en_out_7_0, en_out_15_8, en_pwm_7_0, en_pwm_15_8, pwm_duty;
  logic       wr_strobe, frame_err;

  always #5 clk = ~clk;

  spi_reg_slave #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(MAX_ADDR)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .copi        (copi),
    .ncs         (ncs),
    .en_out_7_0  (en_out_7_0),
    .en_out_15_8 (en_out_15_8),
    .en_pwm_7_0  (en_pwm_7_0),
    .en_pwm_15_8 (en_pwm_15_8),
    .pwm_duty    (pwm_duty),
    .wr_strobe   (wr_strobe),
    .frame_err   (frame_err)
  );

  int checks = 0;
  int passed = 0;
  int n_wr   = 0;
  int n_err  = 0;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_strobe) n_wr++;
    if (frame_err) n_err++;
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [39:0] regs_now();
    return {pwm_duty, en_pwm_15_8, en_pwm_7_0, en_out_15_8, en_out_7_0};
  endfunction

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int first, input int last, input int half);
    for (int i = first; i >= last; i--) begin
      copi = v[i];
      clks(half);
      sclk = 1'b1;
      clks(half);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] v, input int nbits, input int half);
    ncs = 1'b0;
    clks(half);
    send_bits(v, nbits - 1, 0, half);
    clks(half);
    ncs = 1'b1;
    clks(10);
  endtask

  // Reference: five-entry register file updated only by well-formed in-range writes.
  logic [7:0] mreg [5];

  task automatic model_frame(input logic [31:0] v, input int nbits, output int ewr, output int eerr);
    int addr;
    ewr = 0;
    eerr = 0;
    addr = int'(v[14:8]);
    if (nbits != 16) eerr = 1;
    else if (v[15] && addr <= int'(MAX_ADDR)) begin
      mreg[addr] = v[7:0];
      ewr = 1;
    end
  endtask

  function automatic logic [39:0] model_regs();
    return {mreg[4], mreg[3], mreg[2], mreg[1], mreg[0]};
  endfunction

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic [39:0] exp_regs;
    int          exp_wr;
    int          exp_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int w0, e0, ewr, eerr, nb, half;
    logic [31:0] v;

    tbl[0] = '{32'h000080AA, 16, 40'h00_00_00_00_AA, 1, 0};
    tbl[1] = '{32'h000081F0, 16, 40'h00_00_00_F0_AA, 1, 0};
    tbl[2] = '{32'h000082CC, 16, 40'h00_00_CC_F0_AA, 1, 0};
    tbl[3] = '{32'h000083FF, 16, 40'h00_FF_CC_F0_AA, 1, 0};
    tbl[4] = '{32'h00008480, 16, 40'h80_FF_CC_F0_AA, 1, 0};
    tbl[5] = '{32'h00000512, 16, 40'h80_FF_CC_F0_AA, 0, 0};
    tbl[6] = '{32'h00008512, 16, 40'h80_FF_CC_F0_AA, 0, 0};
    tbl[7] = '{32'h00000433, 15, 40'h80_FF_CC_F0_AA, 0, 1};
    tbl[8] = '{32'h00010433, 17, 40'h80_FF_CC_F0_AA, 0, 1};
    tbl[9] = '{32'h00008433, 16, 40'h33_FF_CC_F0_AA, 1, 0};

    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(2);
    check("reset_regs", regs_now(), 40'h0);
    check("reset_pulses", {38'h0, wr_strobe, frame_err}, 40'h0);

    // Basic write with exact commit latency.
    w0 = n_wr; e0 = n_err;
    ncs = 1'b0;
    clks(4);
    send_bits(32'h8055, 15, 0, 4);
    clks(4);
    ncs = 1'b1;
    clks(SYNC_STAGES);
    check("latency_early", {31'h0, wr_strobe, en_out_7_0}, 40'h0);
    clks(1);
    check("latency_land", {31'h0, wr_strobe, en_out_7_0}, 40'h155);
    clks(1);
    check("strobe_one_cycle", {39'h0, wr_strobe}, 40'h0);
    clks(8);
    check("basic_regs", regs_now(), 40'h55);
    check("basic_wr_count", 40'(n_wr - w0), 40'd1);
    check("basic_err_count", 40'(n_err - e0), 40'd0);

    for (int i = 0; i < 10; i++) begin
      w0 = n_wr; e0 = n_err;
      send_frame(tbl[i].bits, tbl[i].nbits, 4);
      check($sformatf("vec%0d_regs", i), regs_now(), tbl[i].exp_regs);
      check($sformatf("vec%0d_wr", i), 40'(n_wr - w0), 40'(tbl[i].exp_wr));
      check($sformatf("vec%0d_err", i), 40'(n_err - e0), 40'(tbl[i].exp_err));
    end

    // Reset in the middle of a frame; the tail of that frame must not write.
    w0 = n_wr;
    ncs = 1'b0;
    clks(4);
    send_bits(32'h8077, 15, 8, 4);
    rst = 1'b1;
    clks(2);
    check("midrst_regs", regs_now(), 40'h0);
    check("midrst_pulses", {38'h0, wr_strobe, frame_err}, 40'h0);
    rst = 1'b0;
    send_bits(32'h8077, 7, 0, 4);
    clks(4);
    ncs = 1'b1;
    clks(10);
    check("midrst_tail_regs", regs_now(), 40'h0);
    check("midrst_tail_wr", 40'(n_wr - w0), 40'd0);

    for (int i = 0; i < 5; i++) mreg[i] = 8'h00;
    w0 = n_wr;
    send_frame(32'h8211, 16, 4);
    model_frame(32'h8211, 16, ewr, eerr);
    check("after_rst_regs", regs_now(), 40'h00_00_11_00_00);
    check("after_rst_wr", 40'(n_wr - w0), 40'd1);

    // Random frames, lengths and SCLK rates against the model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: nb = 15;
        1: nb = 17;
        default: nb = 16;
      endcase
      v = $urandom;
      v[15] = ($urandom_range(0, 3) != 0);
      v[14:8] = 7'($urandom_range(0, 6));
      half = $urandom_range(2, 5);
      w0 = n_wr; e0 = n_err;
      send_frame(v, nb, half);
      model_frame(v, nb, ewr, eerr);
      check($sformatf("rnd%0d_regs", i), regs_now(), model_regs());
      check($sformatf("rnd%0d_wr", i), 40'(n_wr - w0), 40'(ewr));
      check($sformatf("rnd%0d_err", i), 40'(n_err - e0), 40'(eerr));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
